// File: rtl/core_lsu_mem_resp.sv
// core_lsu_mem_resp: single-outstanding LSU data-memory responder with a programmable response latency.
// Access-fault checking (addr >= DEPTH*8) is compiled in when CORE_MEM_RESP_ERR_CHK_EN is defined.
module core_lsu_mem_resp #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned NB       = XLEN / 8;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_accept;
  logic            w_rsp_hs;
  logic            w_fault;
  logic            w_unused_addr;
  logic [AW-1:0]   w_idx;

  assign w_idx     = req_addr[AW+2:3];
  assign w_accept  = r_req_ready & req_valid;
  assign w_rsp_hs  = r_rsp_valid & rsp_ready;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

`ifdef CORE_MEM_RESP_ERR_CHK_EN
  logic r_err;

  assign w_fault       = |req_addr[XLEN-1:AW+3];
  assign w_unused_addr = ^req_addr[2:0];
  assign rsp_err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_fault;
    end else if (w_rsp_hs) begin
      r_err <= 1'b0;
    end
  end
`else
  // Upper address bits are dropped so accesses wrap modulo DEPTH*8.
  assign w_fault       = 1'b0;
  assign w_unused_addr = ^{req_addr[XLEN-1:AW+3], req_addr[2:0]};
  assign rsp_err       = 1'b0;
`endif

  // Array has no reset: stores committed before a reset must survive it.
  always_ff @(posedge clk) begin
    if (w_accept && req_wen && !w_fault) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (req_wmask[b]) begin
          r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt       <= CNT_INIT;
            r_rdata     <= (req_wen || w_fault) ? '0 : r_mem[w_idx];
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
